// File: rtl/jk_mod_counter.sv
// Up/down modulo-MODULUS counter built from per-bit JK flip-flops with
// synchronous load, wrap/saturate end behaviour and terminal-count/wrap outputs.
module jk_mod_counter #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned MODULUS  = 10,
  parameter int unsigned SATURATE = 0
) (
  input  logic             clk,
  input  logic             res,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);
  localparam bit               SAT = (SATURATE != 0);

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] n;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic             wrap_n;
  logic             wrap_r;
  logic             at_top;
  logic             at_bot;

  assign at_top = (q_r == MAX);
  assign at_bot = (q_r == '0);

  // Next count value: load beats enable beats hold
  always_comb begin
    n      = q_r;
    wrap_n = 1'b0;
    if (load) begin
      n = (din > MAX) ? MAX : din;
    end else if (en) begin
      if (up) begin
        if (!at_top) begin
          n = q_r + WIDTH'(1);
        end else if (!SAT) begin
          n      = '0;
          wrap_n = 1'b1;
        end
      end else begin
        if (!at_bot) begin
          n = q_r - WIDTH'(1);
        end else if (!SAT) begin
          n      = MAX;
          wrap_n = 1'b1;
        end
      end
    end
  end

  assign j = n;
  assign k = ~n;

  // One JK flip-flop per count bit
  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_jk
    always_ff @(posedge clk or negedge res) begin
      if (!res) q_r[i] <= 1'b0;
      else      q_r[i] <= (j[i] & ~q_r[i]) | (~k[i] & q_r[i]);
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) wrap_r <= 1'b0;
    else      wrap_r <= wrap_n;
  end

  assign q    = q_r;
  assign wrap = wrap_r;
  assign tc   = en & ~load & (up ? at_top : at_bot);

endmodule

// File: tb/tb_jk_mod_counter.sv
// Scoreboard bench: three counter configurations share one stimulus stream and
// are checked against an arithmetic reference model.
module tb_jk_mod_counter;

  logic       clk = 1'b0;
  logic       res = 1'b0;
  logic       en = 1'b0;
  logic       up = 1'b1;
  logic       load = 1'b0;
  logic [3:0] din = '0;

  logic [3:0] q0, q1;
  logic [2:0] q2;
  logic       tc0, tc1, tc2;
  logic       w0, w1, w2;

  always #5 clk = ~clk;

  // dut0: wrap mod 10, dut1: saturate mod 10, dut2: wrap at natural 3-bit overflow
  jk_mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) dut0 (
    .clk(clk), .res(res), .en(en), .up(up), .load(load), .din(din),
    .q(q0), .tc(tc0), .wrap(w0));
  jk_mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) dut1 (
    .clk(clk), .res(res), .en(en), .up(up), .load(load), .din(din),
    .q(q1), .tc(tc1), .wrap(w1));
  jk_mod_counter #(.WIDTH(3), .MODULUS(8), .SATURATE(0)) dut2 (
    .clk(clk), .res(res), .en(en), .up(up), .load(load), .din(din[2:0]),
    .q(q2), .tc(tc2), .wrap(w2));

  typedef struct packed {
    logic [3:0] q0; logic w0;
    logic [3:0] q1; logic w1;
    logic [2:0] q2; logic w2;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  int mods[3] = '{10, 10, 8};
  int sats[3] = '{0, 1, 0};
  int mq[3]   = '{0, 0, 0};
  int mw[3]   = '{0, 0, 0};

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int dut_q(input int k);
    case (k)
      0:       return int'(q0);
      1:       return int'(q1);
      default: return int'(q2);
    endcase
  endfunction

  function automatic int dut_tc(input int k);
    case (k)
      0:       return int'(tc0);
      1:       return int'(tc1);
      default: return int'(tc2);
    endcase
  endfunction

  function automatic int dut_w(input int k);
    case (k)
      0:       return int'(w0);
      1:       return int'(w1);
      default: return int'(w2);
    endcase
  endfunction

  // Reference model: advance every configuration by one clock edge
  task automatic model_step(input logic e, input logic u, input logic l, input logic [3:0] d);
    int dv;
    for (int k = 0; k < 3; k++) begin
      dv = (k == 2) ? int'(d) % 8 : int'(d);
      if (l) begin
        mq[k] = (dv > mods[k] - 1) ? mods[k] - 1 : dv;
        mw[k] = 0;
      end else if (e) begin
        if (u) begin
          if (mq[k] == mods[k] - 1 && sats[k] != 0) mw[k] = 0;
          else begin
            mw[k] = (mq[k] == mods[k] - 1) ? 1 : 0;
            mq[k] = (mq[k] + 1) % mods[k];
          end
        end else begin
          if (mq[k] == 0 && sats[k] != 0) mw[k] = 0;
          else begin
            mw[k] = (mq[k] == 0) ? 1 : 0;
            mq[k] = (mq[k] + mods[k] - 1) % mods[k];
          end
        end
      end else begin
        mw[k] = 0;
      end
    end
  endtask

  task automatic push_expect();
    exp_t e;
    e.q0 = 4'(mq[0]); e.w0 = 1'(mw[0]);
    e.q1 = 4'(mq[1]); e.w1 = 1'(mw[1]);
    e.q2 = 3'(mq[2]); e.w2 = 1'(mw[2]);
    sb.push_back(e);
  endtask

  // Drive one cycle of stimulus between edges, check tc, queue the edge result
  task automatic step(input logic e, input logic u, input logic l, input logic [3:0] d);
    int exp_tc;
    @(negedge clk);
    en = e; up = u; load = l; din = d;
    #1;
    for (int k = 0; k < 3; k++) begin
      exp_tc = (e && !l && (u ? (mq[k] == mods[k] - 1) : (mq[k] == 0))) ? 1 : 0;
      check($sformatf("tc dut%0d", k), dut_tc(k), exp_tc);
    end
    model_step(e, u, l, d);
    push_expect();
  endtask

  // Assert reset between edges and confirm the asynchronous clear
  task automatic async_reset();
    @(negedge clk);
    en = 1'b0; load = 1'b0;
    res = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("async q dut%0d", k), dut_q(k), 0);
      check($sformatf("async wrap dut%0d", k), dut_w(k), 0);
      mq[k] = 0; mw[k] = 0;
    end
    #1 res = 1'b1;
    push_expect();
  endtask

  // Monitor: compare registered outputs just after every clock edge that has an expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("q dut0", int'(q0), int'(e.q0));
        check("wrap dut0", int'(w0), int'(e.w0));
        check("q dut1", int'(q1), int'(e.q1));
        check("wrap dut1", int'(w1), int'(e.w1));
        check("q dut2", int'(q2), int'(e.q2));
        check("wrap dut2", int'(w2), int'(e.w2));
      end
    end
  end

  initial begin
    // Held in reset across two enabled edges
    en = 1'b1; up = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("reset q dut%0d", k), dut_q(k), 0);
      check($sformatf("reset wrap dut%0d", k), dut_w(k), 0);
    end
    en = 1'b0;
    res = 1'b1;
    push_expect();

    repeat (3) step(1'b1, 1'b1, 1'b0, 4'd0);

    // Up wrap from 8
    step(1'b0, 1'b1, 1'b1, 4'd8);
    repeat (3) step(1'b1, 1'b1, 1'b0, 4'd0);

    // Down wrap from 1
    step(1'b0, 1'b0, 1'b1, 4'd1);
    repeat (3) step(1'b1, 1'b0, 1'b0, 4'd0);

    // Saturate at top, then turn around
    step(1'b0, 1'b1, 1'b1, 4'd9);
    repeat (3) step(1'b1, 1'b1, 1'b0, 4'd0);
    step(1'b1, 1'b0, 1'b0, 4'd0);

    // Load priority and clamp
    step(1'b1, 1'b1, 1'b1, 4'd13);
    step(1'b0, 1'b0, 1'b1, 4'd5);
    step(1'b1, 1'b0, 1'b1, 4'd15);

    // Async reset mid-count at 6
    step(1'b0, 1'b1, 1'b1, 4'd6);
    step(1'b0, 1'b1, 1'b0, 4'd0);
    async_reset();

    // Async reset during the wrap pulse
    step(1'b0, 1'b1, 1'b1, 4'd9);
    step(1'b1, 1'b1, 1'b0, 4'd0);
    async_reset();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) async_reset();
      else step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 7) == 0), 4'($urandom_range(0, 15)));
    end

    repeat (3) @(negedge clk);
    check("scoreboard drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/jk_mod_counter.md
Name: jk_mod_counter

Overview:
- Parametrised up/down modulo-N counter whose state bits are JK flip-flops, each with an asynchronous active-low clear.
- Generalises the team's fixed 2-bit JK sequential circuits to WIDTH bits and a configurable modulus.
- Adds direction control, synchronous load, wrap or saturate mode, and terminal-count and wrap-event outputs.
- Used as a generic sequencer/timer in lab sequential designs.

Parameters:
- WIDTH, 4, counter width in bits; 2..16.
- MODULUS, 10, count range 0..MODULUS-1; 2 <= MODULUS <= 2**WIDTH.
- SATURATE, 0, 0 = wrap at range ends; 1 = hold at range ends.

Ports:
- clk  input  1  rising-edge clock.
- res  input  1  asynchronous active-low reset.
- en  input  1  count enable.
- up  input  1  direction: 1 = increment, 0 = decrement.
- load  input  1  synchronous load request.
- din  input  WIDTH  load value.
- q  output  WIDTH  current count (JK flip-flop outputs).
- tc  output  1  terminal count, combinational.
- wrap  output  1  registered one-cycle wrap-event pulse.

Behaviour:
- Interface: one clock, clk; reset res is asynchronous and active-low.
- Reset:
  - res=0 forces q=0 and wrap=0 immediately, independent of clk.
  - The counter holds while res=0.
  - The first update occurs on the first rising clk edge after res rises.
- State elements:
  - Each q bit is a JK flip-flop: Q+ = J&~Q | ~K&Q.
  - J and K are derived per bit from the next-state value n: J=n, K=~n. Any equivalent toggle form (J=K=T) is acceptable if results match.
  - No plain D-register is used for q.
- Priority at each rising clk edge: load > en > hold.
- Load (load=1):
  - q <= din if din <= MODULUS-1; otherwise q <= MODULUS-1 (clamped).
  - Ignores en and up.
  - wrap <= 0.
- Count (load=0, en=1, up=1):
  - If q < MODULUS-1: q <= q+1.
  - If q == MODULUS-1 and SATURATE=0: q <= 0, wrap <= 1.
  - If q == MODULUS-1 and SATURATE=1: q holds, wrap <= 0.
- Count (load=0, en=1, up=0):
  - If q > 0: q <= q-1.
  - If q == 0 and SATURATE=0: q <= MODULUS-1, wrap <= 1.
  - If q == 0 and SATURATE=1: q holds, wrap <= 0.
- Hold (load=0, en=0): q holds, wrap <= 0.
- Outputs:
  - wrap is high for exactly the one cycle following a wrapping edge.
  - tc = en & ~load & (up ? q==MODULUS-1 : q==0). It is combinational and zero-latency.
- Arithmetic:
  - Compares and increments are unsigned, WIDTH bits.
  - q never leaves 0..MODULUS-1 after reset.
  - When MODULUS = 2**WIDTH, wrap follows natural binary overflow.
- Direction change mid-count: takes effect at the next edge; no extra state.
- Reset asserted mid-count or mid-wrap-pulse clears q and wrap asynchronously.

Test Plan:
- Reset: WIDTH=4, MODULUS=10; hold res=0 across 2 edges with en=1 -> q=0, wrap=0. Release res; 3 edges en=1 up=1 -> q=1,2,3.
- Up wrap, SATURATE=0: load din=8, then en=1 up=1 -> q=9 (tc=1), then q=0 with wrap=1 for one cycle, then q=1 with wrap=0.
- Down wrap: load 1, en=1 up=0 -> q=0 (tc=1), then q=9 with wrap=1, then q=8.
- Saturate: SATURATE=1; load 9, up=1, 3 edges -> q stays 9, wrap stays 0. Then up=0 -> q=8.
- Load priority and clamp: load=1 din=13 en=1 -> q=9. Then load=1 din=5 with en=0 -> q=5.
- Async reset mid-operation: count to q=6; drop res between edges -> q=0 immediately, before the next clk edge. Also drop res on the wrap-pulse cycle -> wrap clears immediately.
